// File: rtl/perf_event_counter_bank_if.sv
// Control, event and read-port bundle for perf_event_counter_bank.
// master drives events/requests and receives counts; slave is the counter bank.
interface perf_event_counter_bank_if #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = $clog2(NUM_CH + 1);

  logic              en;
  logic              clr;
  logic              halt;
  logic [NUM_CH-1:0] event_in;
  logic              snap_req;
  logic              rd_en;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_shadow;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH:0]   ovf;
  logic [CNT_W-1:0]  cycle_count;
  logic              halted;
  logic              snap_done;

  modport master (
    output en, clr, halt, event_in, snap_req, rd_en, rd_sel, rd_shadow,
    input  rd_data, rd_valid, ovf, cycle_count, halted, snap_done
  );

  modport slave (
    input  en, clr, halt, event_in, snap_req, rd_en, rd_sel, rd_shadow,
    output rd_data, rd_valid, ovf, cycle_count, halted, snap_done
  );
endinterface

// File: rtl/perf_event_counter_bank.sv
// NUM_CH event counters plus a cycle counter, with halt freeze, snapshot shadow bank and read port.
// Read latency 1 cycle; no backpressure, one read accepted per cycle, snapshots acknowledged next cycle.
module perf_event_counter_bank #(
  parameter int NUM_CH   = 6,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0
) (
  input logic clk,
  input logic rst,
  perf_event_counter_bank_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH + 1);
  localparam int NCNT  = NUM_CH + 1;
  localparam logic [SEL_W-1:0] CYC_SEL = SEL_W'(NUM_CH);

  logic [CNT_W-1:0] liveCnt   [NCNT];
  logic [CNT_W-1:0] shadowCnt [NCNT];
  logic [NCNT-1:0]  incVec;
  logic [NCNT-1:0]  ovfReg;
  logic             cntActive;
  logic             haltedReg;
  logic             snapDoneReg;
  logic [CNT_W-1:0] rdMux;
  logic [CNT_W-1:0] rdDataReg;
  logic             rdValidReg;

  assign cntActive = bus.en & ~haltedReg;
  // Top bit of the increment vector is the cycle counter.
  assign incVec    = cntActive ? {1'b1, bus.event_in} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) liveCnt[i] <= '0;
      ovfReg <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < NCNT; i++) liveCnt[i] <= '0;
      ovfReg <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (incVec[i]) begin
          if (&liveCnt[i]) begin
            ovfReg[i]  <= 1'b1;
            liveCnt[i] <= (SAT_MODE != 0) ? liveCnt[i] : '0;
          end else begin
            liveCnt[i] <= liveCnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Shadow captures the pre-increment live value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) shadowCnt[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < NCNT; i++) shadowCnt[i] <= '0;
    end else if (bus.snap_req) begin
      for (int i = 0; i < NCNT; i++) shadowCnt[i] <= liveCnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      haltedReg   <= 1'b0;
      snapDoneReg <= 1'b0;
    end else begin
      snapDoneReg <= bus.snap_req & ~bus.clr;
      if (bus.clr)
        haltedReg <= 1'b0;
      else if (bus.halt && cntActive)
        haltedReg <= 1'b1;
    end
  end

  always_comb begin
    rdMux = '0;
    if (bus.rd_sel <= CYC_SEL)
      rdMux = bus.rd_shadow ? shadowCnt[bus.rd_sel] : liveCnt[bus.rd_sel];
  end

  // Read path ignores clr so a same-cycle read returns the pre-clear value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdDataReg  <= '0;
      rdValidReg <= 1'b0;
    end else begin
      rdValidReg <= bus.rd_en;
      if (bus.rd_en)
        rdDataReg <= rdMux;
    end
  end

  assign bus.rd_data     = rdDataReg;
  assign bus.rd_valid    = rdValidReg;
  assign bus.ovf         = ovfReg;
  assign bus.cycle_count = liveCnt[NUM_CH];
  assign bus.halted      = haltedReg;
  assign bus.snap_done   = snapDoneReg;
endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Directed bench for perf_event_counter_bank: a wrapping and a saturating 8-bit instance share stimulus,
// read results are checked against a scoreboard of expected values pushed at request time.
module tb_perf_event_counter_bank;
  logic clk;
  logic rstN;
  int   nTests = 0;
  int   nFail  = 0;
  int   rdIdx  = 0;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] s;
  } exp_t;
  exp_t sbq[$];

  perf_event_counter_bank_if #(.NUM_CH(6), .CNT_W(8)) ifW ();
  perf_event_counter_bank_if #(.NUM_CH(6), .CNT_W(8)) ifS ();

  perf_event_counter_bank #(.NUM_CH(6), .CNT_W(8), .SAT_MODE(0)) dutW (
    .clk(clk), .rst(rstN), .bus(ifW));
  perf_event_counter_bank #(.NUM_CH(6), .CNT_W(8), .SAT_MODE(1)) dutS (
    .clk(clk), .rst(rstN), .bus(ifS));

  assign ifS.en        = ifW.en;
  assign ifS.clr       = ifW.clr;
  assign ifS.halt      = ifW.halt;
  assign ifS.event_in  = ifW.event_in;
  assign ifS.snap_req  = ifW.snap_req;
  assign ifS.rd_en     = ifW.rd_en;
  assign ifS.rd_sel    = ifW.rd_sel;
  assign ifS.rd_shadow = ifW.rd_shadow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int sel, input logic sh, input logic [7:0] w, input logic [7:0] s);
    ifW.rd_en     = 1'b1;
    ifW.rd_sel    = 3'(sel);
    ifW.rd_shadow = sh;
    sbq.push_back('{w: w, s: s});
    tick();
  endtask

  task automatic rdDone();
    ifW.rd_en = 1'b0;
    tick();
  endtask

  task automatic chkZero(input string tag);
    check({tag, "_rdata_w"}, ifW.rd_data, 0);
    check({tag, "_rdata_s"}, ifS.rd_data, 0);
    check({tag, "_rvld_w"}, ifW.rd_valid, 0);
    check({tag, "_rvld_s"}, ifS.rd_valid, 0);
    check({tag, "_ovf_w"}, ifW.ovf, 0);
    check({tag, "_ovf_s"}, ifS.ovf, 0);
    check({tag, "_cyc_w"}, ifW.cycle_count, 0);
    check({tag, "_cyc_s"}, ifS.cycle_count, 0);
    check({tag, "_halted_w"}, ifW.halted, 0);
    check({tag, "_snapdone_w"}, ifW.snap_done, 0);
  endtask

  // Read-result monitor: pops one expectation per rd_valid pulse.
  always @(negedge clk) begin
    if (rstN && ifW.rd_valid) begin
      if (sbq.size() == 0) begin
        check($sformatf("rd%0d_unexpected_valid", rdIdx), 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check($sformatf("rd%0d_data_w", rdIdx), ifW.rd_data, e.w);
        check($sformatf("rd%0d_vld_s", rdIdx), ifS.rd_valid, 1);
        check($sformatf("rd%0d_data_s", rdIdx), ifS.rd_data, e.s);
      end
      rdIdx++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN          = 1'b0;
    ifW.en        = 1'b0;
    ifW.clr       = 1'b0;
    ifW.halt      = 1'b0;
    ifW.event_in  = '0;
    ifW.snap_req  = 1'b0;
    ifW.rd_en     = 1'b0;
    ifW.rd_sel    = '0;
    ifW.rd_shadow = 1'b0;
    tick();
    chkZero("reset");
    tick();
    rstN = 1'b1;

    // 10 strobes on ch0
    ifW.en       = 1'b1;
    ifW.event_in = 6'b000001;
    repeat (10) tick();
    ifW.en       = 1'b0;
    ifW.event_in = '0;
    check("t1_cyc_w", ifW.cycle_count, 10);
    check("t1_cyc_s", ifS.cycle_count, 10);
    rd(0, 1'b0, 8'd10, 8'd10);
    rdDone();

    // 256 strobes on ch1: wrap vs saturate; cycle counter overflows too
    ifW.en       = 1'b1;
    ifW.event_in = 6'b000010;
    repeat (256) tick();
    ifW.en       = 1'b0;
    ifW.event_in = '0;
    check("t2_ovf_w", ifW.ovf, 7'b1000010);
    check("t2_ovf_s", ifS.ovf, 7'b1000010);
    check("t2_cyc_s", ifS.cycle_count, 8'hFF);
    rd(0, 1'b0, 8'd10, 8'd10);
    rd(1, 1'b0, 8'h00, 8'hFF);
    rd(7, 1'b0, 8'h00, 8'h00);
    rdDone();

    // ch2 to 5, then snapshot with a same-cycle event and shadow read
    ifW.en       = 1'b1;
    ifW.event_in = 6'b000100;
    repeat (5) tick();
    ifW.snap_req = 1'b1;
    rd(2, 1'b1, 8'd0, 8'd0);
    ifW.snap_req = 1'b0;
    ifW.en       = 1'b0;
    ifW.event_in = '0;
    ifW.rd_en    = 1'b0;
    check("t4_snapdone_w", ifW.snap_done, 1);
    check("t4_snapdone_s", ifS.snap_done, 1);
    tick();
    check("t4_snapdone_drop", ifW.snap_done, 0);
    rd(2, 1'b1, 8'd5, 8'd5);
    rd(2, 1'b0, 8'd6, 8'd6);
    rd(0, 1'b1, 8'd10, 8'd10);
    rd(1, 1'b1, 8'h00, 8'hFF);
    rdDone();
    ifW.snap_req = 1'b1;
    tick();
    check("t4_b2b_snap1", ifW.snap_done, 1);
    tick();
    check("t4_b2b_snap2", ifW.snap_done, 1);
    ifW.snap_req = 1'b0;
    tick();
    check("t4_b2b_snap_end", ifW.snap_done, 0);

    // halt with same-cycle events, then frozen
    ifW.en       = 1'b1;
    ifW.halt     = 1'b1;
    ifW.event_in = 6'b000011;
    tick();
    ifW.halt     = 1'b0;
    ifW.event_in = 6'b111111;
    check("t3_halted_w", ifW.halted, 1);
    check("t3_halted_s", ifS.halted, 1);
    repeat (5) tick();
    ifW.event_in = '0;
    rd(0, 1'b0, 8'd11, 8'd11);
    rd(1, 1'b0, 8'd1, 8'hFF);
    rd(2, 1'b0, 8'd6, 8'd6);
    rd(3, 1'b0, 8'd0, 8'd0);
    rdDone();
    check("t3_ovf_w", ifW.ovf, 7'b1000010);
    ifW.snap_req = 1'b1;
    tick();
    ifW.snap_req = 1'b0;
    check("t3_snap_halted", ifW.snap_done, 1);
    rd(0, 1'b1, 8'd11, 8'd11);
    rd(1, 1'b1, 8'd1, 8'hFF);
    rdDone();

    // clr wins over snap_req, halt and events; same-cycle read sees pre-clear value
    ifW.clr      = 1'b1;
    ifW.snap_req = 1'b1;
    ifW.halt     = 1'b1;
    ifW.event_in = 6'b111111;
    rd(0, 1'b0, 8'd11, 8'd11);
    ifW.clr      = 1'b0;
    ifW.snap_req = 1'b0;
    ifW.halt     = 1'b0;
    ifW.event_in = '0;
    ifW.en       = 1'b0;
    ifW.rd_en    = 1'b0;
    check("t5_snapdone", ifW.snap_done, 0);
    check("t5_halted_w", ifW.halted, 0);
    check("t5_halted_s", ifS.halted, 0);
    check("t5_ovf_w", ifW.ovf, 0);
    check("t5_ovf_s", ifS.ovf, 0);
    check("t5_cyc_w", ifW.cycle_count, 0);
    rd(0, 1'b0, 8'd0, 8'd0);
    rd(0, 1'b1, 8'd0, 8'd0);
    rd(2, 1'b1, 8'd0, 8'd0);
    rd(1, 1'b0, 8'd0, 8'd0);
    rdDone();
    check("t5_halted_later", ifW.halted, 0);

    // async reset mid-operation
    ifW.en       = 1'b1;
    ifW.event_in = 6'b000001;
    repeat (3) tick();
    ifW.en       = 1'b0;
    ifW.event_in = '0;
    rd(0, 1'b0, 8'd3, 8'd3);
    rdDone();
    check("t6_rdata_hold", ifW.rd_data, 3);
    ifW.en       = 1'b1;
    ifW.event_in = 6'b000001;
    #2;
    rstN = 1'b0;
    #1;
    chkZero("t6_async");
    tick();
    tick();
    check("t6_held_cyc", ifW.cycle_count, 0);
    rstN = 1'b1;
    repeat (3) tick();
    ifW.en       = 1'b0;
    ifW.event_in = '0;
    check("t6_resume_cyc_w", ifW.cycle_count, 3);
    check("t6_resume_cyc_s", ifS.cycle_count, 3);
    rd(0, 1'b0, 8'd3, 8'd3);
    rdDone();
    tick();
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
